// File: rtl/sequenciador_sensores_pkg.sv
// Shared constants for the roberto sensor sequencer: state codes, sensor count
// and sensor-index width.
package roberto_pkg;

  localparam int N_SENSORES = 3;
  localparam int SEL_W      = 2;

  localparam logic [3:0] EST_INICIAL        = 4'd0;
  localparam logic [3:0] EST_PREPARA        = 4'd1;
  localparam logic [3:0] EST_MEDE           = 4'd2;
  localparam logic [3:0] EST_AGUARDA_MEDIDA = 4'd3;
  localparam logic [3:0] EST_TRANSMITE      = 4'd4;
  localparam logic [3:0] EST_AGUARDA_TX     = 4'd5;
  localparam logic [3:0] EST_PROXIMO        = 4'd6;
  localparam logic [3:0] EST_FIM            = 4'd7;
  localparam logic [3:0] EST_ESPERA         = 4'd8;

  typedef enum logic [3:0] {
    INICIAL        = EST_INICIAL,
    PREPARA        = EST_PREPARA,
    MEDE           = EST_MEDE,
    AGUARDA_MEDIDA = EST_AGUARDA_MEDIDA,
    TRANSMITE      = EST_TRANSMITE,
    AGUARDA_TX     = EST_AGUARDA_TX,
    PROXIMO        = EST_PROXIMO,
    FIM            = EST_FIM,
    ESPERA         = EST_ESPERA
  } estado_t;

  function automatic logic [N_SENSORES-1:0] um_quente(input logic [SEL_W-1:0] idx);
    return N_SENSORES'(1) << idx;
  endfunction

endpackage

// File: rtl/sequenciador_sensores_if.sv
// Handshake bundle between the sequencer (master) and the sensor/serial
// datapath (slave).
interface sequenciador_sensores_if;
  import roberto_pkg::*;

  logic                  ligar;
  logic                  modo_continuo;
  logic [N_SENSORES-1:0] pronto_medida;
  logic                  pronto_serial;
  logic                  zera_sensor;
  logic [N_SENSORES-1:0] medir;
  logic [SEL_W-1:0]      sel_sensor;
  logic                  partida_tx;
  logic                  timeout_medida;
  logic                  ocupado;
  logic                  pronto;
  logic [3:0]            db_estado;

  modport master (
    input  ligar, modo_continuo, pronto_medida, pronto_serial,
    output zera_sensor, medir, sel_sensor, partida_tx, timeout_medida,
           ocupado, pronto, db_estado
  );

  modport slave (
    output ligar, modo_continuo, pronto_medida, pronto_serial,
    input  zera_sensor, medir, sel_sensor, partida_tx, timeout_medida,
           ocupado, pronto, db_estado
  );

endinterface

// File: rtl/sequenciador_sensores_contador.sv
// Modulo-M counter that saturates at M-1; fim flags the terminal count so the
// owner can leave its state without the counter ever wrapping.
module contador_m #(
  parameter  int M = 16,
  localparam int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [W-1:0] q;

  always_ff @(posedge clock) begin
    if (reset || zera)
      q <= '0;
    else if (conta && !fim)
      q <= q + W'(1);
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/sequenciador_sensores.sv
// Sweeps the three ultrasonic channels (measure, then transmit each result),
// with a per-measurement timeout and an optional periodic repeat.
module sequenciador_sensores
  import roberto_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 1_500_000,
  parameter int PERIODO_CICLOS = 25_000_000
) (
  input logic                     clock,
  input logic                     reset,
  sequenciador_sensores_if.master bus
);

  estado_t          estado, estado_prox;
  logic [SEL_W-1:0] sel, sel_prox;
  logic             flag_to, flag_to_prox;
  logic             fim_timeout, fim_periodo;

  logic                  zera_d, partida_d, to_d, ocupado_d, pronto_d;
  logic [N_SENSORES-1:0] medir_d;

  // Each counter is cleared by the state that precedes its owning state.
  contador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado == PREPARA),
    .conta (estado == AGUARDA_MEDIDA),
    .fim   (fim_timeout)
  );

  contador_m #(.M(PERIODO_CICLOS)) u_periodo (
    .clock (clock),
    .reset (reset),
    .zera  (estado == FIM),
    .conta (estado == ESPERA),
    .fim   (fim_periodo)
  );

  always_comb begin
    estado_prox  = estado;
    sel_prox     = sel;
    flag_to_prox = flag_to;
    case (estado)
      INICIAL: begin
        if (bus.ligar) begin
          estado_prox = PREPARA;
          sel_prox    = '0;
        end
      end
      PREPARA: estado_prox = MEDE;
      MEDE:    estado_prox = AGUARDA_MEDIDA;
      // A real answer beats a timeout landing in the same cycle.
      AGUARDA_MEDIDA: begin
        if (bus.pronto_medida[sel]) begin
          estado_prox  = TRANSMITE;
          flag_to_prox = 1'b0;
        end else if (fim_timeout) begin
          estado_prox  = TRANSMITE;
          flag_to_prox = 1'b1;
        end
      end
      TRANSMITE: estado_prox = AGUARDA_TX;
      AGUARDA_TX: begin
        if (bus.pronto_serial)
          estado_prox = PROXIMO;
      end
      PROXIMO: begin
        if (sel < SEL_W'(N_SENSORES - 1)) begin
          sel_prox    = sel + SEL_W'(1);
          estado_prox = PREPARA;
        end else begin
          estado_prox = FIM;
        end
      end
      FIM: begin
        sel_prox    = '0;
        estado_prox = bus.modo_continuo ? ESPERA : INICIAL;
      end
      ESPERA: begin
        if (!bus.modo_continuo)
          estado_prox = INICIAL;
        else if (fim_periodo)
          estado_prox = PREPARA;
      end
      default: begin
        estado_prox  = INICIAL;
        sel_prox     = '0;
        flag_to_prox = 1'b0;
      end
    endcase

    zera_d    = (estado_prox == PREPARA);
    medir_d   = (estado_prox == MEDE) ? um_quente(sel_prox) : '0;
    partida_d = (estado_prox == TRANSMITE);
    to_d      = flag_to_prox && ((estado_prox == TRANSMITE) || (estado_prox == AGUARDA_TX));
    ocupado_d = (estado_prox != INICIAL);
    pronto_d  = (estado_prox == FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado             <= INICIAL;
      sel                <= '0;
      flag_to            <= 1'b0;
      bus.zera_sensor    <= 1'b0;
      bus.medir          <= '0;
      bus.partida_tx     <= 1'b0;
      bus.timeout_medida <= 1'b0;
      bus.ocupado        <= 1'b0;
      bus.pronto         <= 1'b0;
    end else begin
      estado             <= estado_prox;
      sel                <= sel_prox;
      flag_to            <= flag_to_prox;
      bus.zera_sensor    <= zera_d;
      bus.medir          <= medir_d;
      bus.partida_tx     <= partida_d;
      bus.timeout_medida <= to_d;
      bus.ocupado        <= ocupado_d;
      bus.pronto         <= pronto_d;
    end
  end

  assign bus.sel_sensor = sel;
  assign bus.db_estado  = estado;

endmodule

// File: tb/tb_sequenciador_sensores.sv
// Bench for sequenciador_sensores: directed and random sweeps compared against
// a timeline model built from the sweep latencies.
module tb_sequenciador_sensores;
  import roberto_pkg::*;

  localparam int TO  = 20;
  localparam int PER = 50;

  logic clock = 1'b0;
  logic reset;

  sequenciador_sensores_if ifc ();

  sequenciador_sensores #(
    .TIMEOUT_CICLOS (TO),
    .PERIODO_CICLOS (PER)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.master)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;

  // Responder configuration: resp_d[i] cycles after medir (0 = silent).
  int resp_d [3];
  int tx_d;
  bit ligar_in_tx;
  int xtalk_off;
  int ligar_at;

  int resp_at, resp_bit, ser_at, xtalk_at, last_partida;

  int zera_q[$], medir_c[$], medir_v[$], part_c[$], part_sel[$], part_to[$];
  int ser_to[$], ser_sel[$], pronto_q[$];
  int ez[$], em_c[$], em_v[$], ep_c[$], ep_to[$], epr[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expected);
    end
  endtask

  task automatic clear_all();
    zera_q.delete(); medir_c.delete(); medir_v.delete();
    part_c.delete(); part_sel.delete(); part_to.delete();
    ser_to.delete(); ser_sel.delete(); pronto_q.delete();
    ez.delete(); em_c.delete(); em_v.delete();
    ep_c.delete(); ep_to.delete(); epr.delete();
    resp_at = -1; ser_at = -1; xtalk_at = -1; last_partida = -1; ligar_at = -1;
    resp_bit = 0;
  endtask

  // One clock: observe this cycle's outputs, then drive this cycle's inputs.
  task automatic tick();
    logic [2:0] pm;
    @(negedge clock);
    cyc++;
    if (ifc.zera_sensor === 1'b1) zera_q.push_back(cyc);
    if (ifc.medir !== 3'b000 && !$isunknown(ifc.medir)) begin
      medir_c.push_back(cyc);
      medir_v.push_back(int'(ifc.medir));
      resp_at = -1;
      for (int i = 0; i < 3; i++) begin
        if (ifc.medir[i]) begin
          if (resp_d[i] > 0) begin
            resp_at  = cyc + resp_d[i];
            resp_bit = i;
          end
          if (i == 1 && xtalk_off > 0) xtalk_at = cyc + xtalk_off;
        end
      end
    end
    if (ifc.partida_tx === 1'b1) begin
      part_c.push_back(cyc);
      part_sel.push_back(int'(ifc.sel_sensor));
      part_to.push_back(int'(ifc.timeout_medida));
      ser_at       = cyc + tx_d;
      last_partida = cyc;
    end
    if (ifc.pronto === 1'b1) pronto_q.push_back(cyc);
    pm = 3'b000;
    if (cyc == resp_at) pm[resp_bit] = 1'b1;
    if (cyc == xtalk_at) pm[0] = 1'b1;
    ifc.pronto_medida = pm;
    ifc.pronto_serial = (cyc == ser_at);
    if (cyc == ser_at) begin
      ser_to.push_back(int'(ifc.timeout_medida));
      ser_sel.push_back(int'(ifc.sel_sensor));
    end
    ifc.ligar = (cyc == ligar_at) || (ligar_in_tx && cyc > last_partida && cyc <= ser_at);
  endtask

  // Expected timeline of one sweep whose zera_sensor lands in cycle z; returns pronto cycle.
  function automatic int model_sweep(input int z);
    int zz, m, p;
    bit answered;
    zz = z;
    for (int i = 0; i < 3; i++) begin
      ez.push_back(zz);
      m = zz + 1;
      em_c.push_back(m);
      em_v.push_back(1 << i);
      answered = (resp_d[i] >= 1) && (resp_d[i] <= TO);
      p = m + (answered ? resp_d[i] : TO) + 1;
      ep_c.push_back(p);
      ep_to.push_back(answered ? 0 : 1);
      zz = p + tx_d + 2;
    end
    epr.push_back(zz);
    return zz;
  endfunction

  task automatic compare_logs(input string tag);
    checkOutput({tag, " zera count"}, zera_q.size(), ez.size());
    foreach (ez[i])
      checkOutput($sformatf("%s zera[%0d]", tag, i), (i < zera_q.size()) ? zera_q[i] : -1, ez[i]);
    checkOutput({tag, " medir count"}, medir_c.size(), em_c.size());
    foreach (em_c[i]) begin
      checkOutput($sformatf("%s medirCyc[%0d]", tag, i), (i < medir_c.size()) ? medir_c[i] : -1, em_c[i]);
      checkOutput($sformatf("%s medirVal[%0d]", tag, i), (i < medir_v.size()) ? medir_v[i] : -1, em_v[i]);
    end
    checkOutput({tag, " partida count"}, part_c.size(), ep_c.size());
    foreach (ep_c[i]) begin
      checkOutput($sformatf("%s partidaCyc[%0d]", tag, i), (i < part_c.size()) ? part_c[i] : -1, ep_c[i]);
      checkOutput($sformatf("%s partidaSel[%0d]", tag, i), (i < part_sel.size()) ? part_sel[i] : -1, i % 3);
      checkOutput($sformatf("%s partidaTo[%0d]", tag, i), (i < part_to.size()) ? part_to[i] : -1, ep_to[i]);
      checkOutput($sformatf("%s txHoldTo[%0d]", tag, i), (i < ser_to.size()) ? ser_to[i] : -1, ep_to[i]);
      checkOutput($sformatf("%s txHoldSel[%0d]", tag, i), (i < ser_sel.size()) ? ser_sel[i] : -1, i % 3);
    end
    checkOutput({tag, " pronto count"}, pronto_q.size(), epr.size());
    foreach (epr[i])
      checkOutput($sformatf("%s prontoCyc[%0d]", tag, i), (i < pronto_q.size()) ? pronto_q[i] : -1, epr[i]);
  endtask

  task automatic applyStimulus(input string tag, input int d0, input int d1, input int d2,
                               input int tx, input bit spur, input int xt);
    int budget;
    clear_all();
    resp_d      = '{d0, d1, d2};
    tx_d        = tx;
    ligar_in_tx = spur;
    xtalk_off   = xt;
    ligar_at    = cyc + 1;
    void'(model_sweep(ligar_at + 1));
    budget = 0;
    while (pronto_q.size() == 0 && budget < 500) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    checkOutput({tag, " ocupado idle"}, ifc.ocupado, 0);
    checkOutput({tag, " estado idle"}, ifc.db_estado, 0);
    compare_logs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " zera_sensor"}, ifc.zera_sensor, 0);
    checkOutput({tag, " medir"}, ifc.medir, 0);
    checkOutput({tag, " sel_sensor"}, ifc.sel_sensor, 0);
    checkOutput({tag, " partida_tx"}, ifc.partida_tx, 0);
    checkOutput({tag, " timeout_medida"}, ifc.timeout_medida, 0);
    checkOutput({tag, " ocupado"}, ifc.ocupado, 0);
    checkOutput({tag, " pronto"}, ifc.pronto, 0);
    checkOutput({tag, " db_estado"}, ifc.db_estado, 0);
  endtask

  initial begin
    int budget;
    int f;
    reset               = 1'b1;
    ifc.ligar           = 1'b0;
    ifc.modo_continuo   = 1'b0;
    ifc.pronto_medida   = 3'b000;
    ifc.pronto_serial   = 1'b0;
    resp_d              = '{0, 0, 0};
    tx_d                = 1;
    ligar_in_tx         = 1'b0;
    xtalk_off           = 0;
    clear_all();

    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    applyStimulus("single", 5, 5, 5, 10, 1'b0, 0);
    applyStimulus("timeout", 5, 0, 5, 10, 1'b0, 0);
    applyStimulus("tieXtalk", 5, 20, 5, 10, 1'b0, 2);
    applyStimulus("ligarInTx", 5, 5, 5, 10, 1'b1, 0);

    for (int k = 0; k < 3; k++)
      applyStimulus($sformatf("rand%0d", k),
                    int'($urandom_range(26, 0)), int'($urandom_range(26, 0)),
                    int'($urandom_range(26, 0)), int'($urandom_range(12, 1)),
                    1'($urandom_range(1, 0)), 0);

    // Continuous mode: three back-to-back sweeps, then drop the mode in ESPERA.
    clear_all();
    ifc.modo_continuo = 1'b1;
    resp_d      = '{5, 5, 5};
    tx_d        = 10;
    ligar_in_tx = 1'b0;
    xtalk_off   = 0;
    ligar_at    = cyc + 1;
    f = model_sweep(ligar_at + 1);
    f = model_sweep(f + PER + 1);
    void'(model_sweep(f + PER + 1));
    budget = 0;
    while (pronto_q.size() < 3 && budget < 1500) begin
      tick();
      budget++;
    end
    repeat (9) tick();
    checkOutput("cont espera", ifc.db_estado, 8);
    ifc.modo_continuo = 1'b0;
    tick();
    checkOutput("cont drop estado", ifc.db_estado, 0);
    checkOutput("cont drop ocupado", ifc.ocupado, 0);
    repeat (60) tick();
    compare_logs("cont");

    // Reset while waiting on a silent sensor.
    clear_all();
    resp_d   = '{0, 0, 0};
    tx_d     = 5;
    ligar_at = cyc + 1;
    budget   = 0;
    while (medir_c.size() == 0 && budget < 20) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    checkOutput("preReset estado", ifc.db_estado, 3);
    reset = 1'b1;
    tick();
    check_reset_values("midReset");
    reset = 1'b0;
    repeat (60) tick();
    checkOutput("postReset pronto count", pronto_q.size(), 0);
    checkOutput("postReset partida count", part_c.size(), 0);
    checkOutput("postReset estado", ifc.db_estado, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
